// File: rtl/hex_parse_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hex_parse_pkg
//  Purpose  : Shared types and ASCII constants for the hex text parser and
//             related command-parsing blocks.
//  Contents : state_e  - parser state encoding (IDLE/ACCUM/EMIT/SKIP)
//             C_ASCII_* - delimiter and prefix character codes
//  Revision : 1.0 - initial release
// ============================================================================
package hex_parse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2,
    ST_SKIP  = 2'd3
  } state_e;

  // Token delimiters
  localparam logic [7:0] C_ASCII_SPACE = 8'h20;
  localparam logic [7:0] C_ASCII_LF    = 8'h0A;
  localparam logic [7:0] C_ASCII_CR    = 8'h0D;
  localparam logic [7:0] C_ASCII_COMMA = 8'h2C;

  // "0x" prefix letter, both cases
  localparam logic [7:0] C_ASCII_X_LO  = 8'h78;
  localparam logic [7:0] C_ASCII_X_UP  = 8'h58;

endpackage : hex_parse_pkg
`default_nettype wire

// File: rtl/ascii_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module   : ascii_hex_decode
//  Purpose  : Combinational classifier for one ASCII byte: hex digit (with
//             its 4-bit value), token delimiter, or 'x'/'X' prefix letter.
//             Inverse of the nibble-to-ASCII formatter.
//  Ports    : char_i      in   8  ASCII byte
//             is_digit_o  out  1  '0'-'9', 'A'-'F', 'a'-'f'
//             is_delim_o  out  1  space, LF, CR, comma
//             is_prefix_o out  1  'x' or 'X'
//             nibble_o    out  4  digit value (0 when not a digit)
//  Revision : 1.0 - initial release
// ============================================================================
module ascii_hex_decode
  import hex_parse_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_digit_o,
  output logic       is_delim_o,
  output logic       is_prefix_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    is_digit_o  = 1'b0;
    is_delim_o  = 1'b0;
    is_prefix_o = 1'b0;
    nibble_o    = 4'd0;

    if (char_i >= 8'h30 && char_i <= 8'h39) begin
      // '0'..'9': value is the low nibble of the code
      is_digit_o = 1'b1;
      nibble_o   = char_i[3:0];
    end else if ((char_i >= 8'h41 && char_i <= 8'h46) ||
                 (char_i >= 8'h61 && char_i <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so add 9 to land on 10..15
      is_digit_o = 1'b1;
      nibble_o   = char_i[3:0] + 4'd9;
    end

    if (char_i == C_ASCII_SPACE || char_i == C_ASCII_LF ||
        char_i == C_ASCII_CR    || char_i == C_ASCII_COMMA) begin
      is_delim_o = 1'b1;
    end

    if (char_i == C_ASCII_X_LO || char_i == C_ASCII_X_UP) begin
      is_prefix_o = 1'b1;
    end
  end

endmodule : ascii_hex_decode
`default_nettype wire

// File: rtl/hex_word_parser.sv
`default_nettype none
// ============================================================================
//  Module   : hex_word_parser
//  Purpose  : Streaming ASCII hex text to binary word parser. Each delimited
//             hex token (optionally "0x"-prefixed) becomes one right-aligned,
//             zero-extended word. Malformed tokens raise a one-cycle err and
//             are skipped up to the next delimiter.
//  Ports    : clk        in   1             rising-edge clock
//             rst        in   1             synchronous active-high reset
//             in_valid   in   1             in_char valid
//             in_ready   out  1             byte accepted this cycle
//             in_char    in   8             ASCII byte
//             out_valid  out  1             out_word holds a token
//             out_ready  in   1             consumer takes the word
//             out_word   out  4*WORD_DIGITS parsed value
//             out_digits out  4             digit count of the token
//             err        out  1             malformed-token pulse
//  Revision : 1.0 - initial release
// ============================================================================
module hex_word_parser
  import hex_parse_pkg::*;
#(
  parameter int WORD_DIGITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_char,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*WORD_DIGITS-1:0] out_word,
  output logic [3:0]               out_digits,
  output logic                     err
);

  localparam int         W         = 4 * WORD_DIGITS;
  localparam logic [3:0] C_MAX_CNT = 4'(WORD_DIGITS);

  state_e         state_q;
  logic [W-1:0]   acc_q;
  logic [3:0]     count_q;
  logic [W-1:0]   out_word_q;
  logic [3:0]     out_digits_q;
  logic           out_valid_q;
  logic           err_q;

  logic           is_digit;
  logic           is_delim;
  logic           is_prefix;
  logic [3:0]     nibble;
  logic           is_invalid;
  logic           byte_fire;
  logic [W-1:0]   acc_shift_d;

  ascii_hex_decode u_decode (
    .char_i      (in_char),
    .is_digit_o  (is_digit),
    .is_delim_o  (is_delim),
    .is_prefix_o (is_prefix),
    .nibble_o    (nibble)
  );

  assign is_invalid  = !(is_digit || is_delim || is_prefix);
  // Ready depends on the state register only, never on in_valid/out_ready
  assign in_ready    = (state_q != ST_EMIT);
  assign byte_fire   = in_valid && in_ready;
  assign acc_shift_d = {acc_q[W-5:0], nibble};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      count_q      <= 4'd0;
      out_word_q   <= '0;
      out_digits_q <= 4'd0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (byte_fire) begin
            if (is_digit) begin
              acc_q   <= W'(nibble);
              count_q <= 4'd1;
              state_q <= ST_ACCUM;
            end else if (!is_delim) begin
              err_q   <= 1'b1;
              state_q <= ST_SKIP;
            end
          end
        end

        ST_ACCUM: begin
          if (byte_fire) begin
            if (is_digit) begin
              if (count_q < C_MAX_CNT) begin
                acc_q   <= acc_shift_d;
                count_q <= count_q + 4'd1;
              end else begin
                // Too many digits: drop the whole token
                err_q   <= 1'b1;
                acc_q   <= '0;
                count_q <= 4'd0;
                state_q <= ST_SKIP;
              end
            end else if (is_prefix) begin
              if (count_q == 4'd1 && acc_q == '0) begin
                // Leading "0x": the zero does not count as a digit
                acc_q   <= '0;
                count_q <= 4'd0;
              end else begin
                err_q   <= 1'b1;
                acc_q   <= '0;
                count_q <= 4'd0;
                state_q <= ST_SKIP;
              end
            end else if (is_delim) begin
              if (count_q != 4'd0) begin
                out_word_q   <= acc_q;
                out_digits_q <= count_q;
                out_valid_q  <= 1'b1;
                state_q      <= ST_EMIT;
              end else begin
                // Bare "0x" with no digits: nothing left to skip
                err_q   <= 1'b1;
                state_q <= ST_IDLE;
              end
            end else if (is_invalid) begin
              err_q   <= 1'b1;
              acc_q   <= '0;
              count_q <= 4'd0;
              state_q <= ST_SKIP;
            end
          end
        end

        ST_EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            count_q     <= 4'd0;
            state_q     <= ST_IDLE;
          end
        end

        ST_SKIP: begin
          if (byte_fire && is_delim) begin
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_word   = out_word_q;
  assign out_digits = out_digits_q;
  assign err        = err_q;

endmodule : hex_word_parser
`default_nettype wire

// File: tb/tb_hex_word_parser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_word_parser
//  Purpose  : Self-checking bench for hex_word_parser: table of text vectors
//             with expected word/digit/err results, plus directed sequences
//             for reset state, latencies, back-pressure and reset recovery.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hex_word_parser;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [3:0]  out_digits;
  logic        err;

  hex_word_parser #(.WORD_DIGITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_digits (out_digits),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor: words taken and err cycles seen, sampled mid-cycle
  int          word_cnt = 0;
  int          err_cnt  = 0;
  logic [31:0] last_word   = '0;
  logic [3:0]  last_digits = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        word_cnt    <= word_cnt + 1;
        last_word   <= out_word;
        last_digits <= out_digits;
      end
      if (err) err_cnt <= err_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one byte at a negedge and hold it until accepted
  task automatic send_byte(input logic [7:0] c);
    bit done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_char  = c;
      if (in_ready) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      in_valid = 1'b0;
      chk("send_timeout", 32'd1, 32'd0);
    end
  endtask

  task automatic send_text(input logic [127:0] t);
    int len = 0;
    for (int i = 0; i < 16; i++) if (t[8*i +: 8] != 8'h00) len = i + 1;
    for (int i = len - 1; i >= 0; i--) send_byte(t[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [127:0] text;
    int           exp_words;
    logic [31:0]  exp_word;
    logic [3:0]   exp_digits;
    int           exp_errs;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  initial begin
    int w0, e0;
    vecs[0]  = '{"1234ABCD\n",   1, 32'h1234ABCD, 4'd8, 0};
    vecs[1]  = '{"0xfF ",        1, 32'h000000FF, 4'd2, 0};
    vecs[2]  = '{"  7,",         1, 32'h00000007, 4'd1, 0};
    vecs[3]  = '{"12G4 5\n",     1, 32'h00000005, 4'd1, 1};
    vecs[4]  = '{"123456789 ",   0, 32'h0,        4'd0, 1};
    vecs[5]  = '{"0x\r",         0, 32'h0,        4'd0, 1};
    vecs[6]  = '{"x12 9\r",      1, 32'h00000009, 4'd1, 1};
    vecs[7]  = '{"1x2 ",         0, 32'h0,        4'd0, 1};
    vecs[8]  = '{"a,b,",         2, 32'h0000000B, 4'd1, 0};
    vecs[9]  = '{"0x12345678\n", 1, 32'h12345678, 4'd8, 0};
    vecs[10] = '{"00x5 ",        0, 32'h0,        4'd0, 1};
    vecs[11] = '{"0X0 ",         1, 32'h00000000, 4'd1, 0};
    vecs[12] = '{"!5 ",          0, 32'h0,        4'd0, 1};

    rst = 1'b1; in_valid = 1'b0; in_char = 8'h00; out_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_word",   out_word,        32'd0);
    chk("rst_out_digits", 32'(out_digits), 32'd0);
    chk("rst_err",        32'(err),        32'd0);

    // ---------------- table-driven vectors ----------------
    for (int v = 0; v < NV; v++) begin
      w0 = word_cnt; e0 = err_cnt;
      send_text(vecs[v].text);
      idle(4);
      @(negedge clk);
      chk($sformatf("v%0d_words", v), 32'(word_cnt - w0), 32'(vecs[v].exp_words));
      chk($sformatf("v%0d_errs", v),  32'(err_cnt - e0),  32'(vecs[v].exp_errs));
      if (vecs[v].exp_words > 0) begin
        chk($sformatf("v%0d_word", v),   last_word,          vecs[v].exp_word);
        chk($sformatf("v%0d_digits", v), 32'(last_digits),   32'(vecs[v].exp_digits));
      end
    end

    // ---------------- err pulse timing ----------------
    send_byte("G");
    @(negedge clk);
    chk("err_pulse_hi", 32'(err), 32'd1);
    @(negedge clk);
    chk("err_pulse_lo", 32'(err), 32'd0);
    send_byte(" ");
    idle(2);

    // ---------------- back-pressure: "AB\n", out_ready low ----------------
    out_ready = 1'b0;
    w0 = word_cnt;
    send_text("AB\n");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", i),  32'(out_valid),  32'd1);
      chk($sformatf("bp_ready_%0d", i),  32'(in_ready),   32'd0);
      chk($sformatf("bp_word_%0d", i),   out_word,        32'h000000AB);
      chk($sformatf("bp_digits_%0d", i), 32'(out_digits), 32'd2);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);                       // transfer edge
    @(negedge clk);
    chk("bp_valid_after", 32'(out_valid), 32'd0);
    chk("bp_ready_after", 32'(in_ready),  32'd1);
    idle(3);
    chk("bp_word_once", 32'(word_cnt - w0), 32'd1);

    // ---------------- reset mid-token ----------------
    send_text("AB");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    w0 = word_cnt;
    send_text("C\n");
    idle(3);
    chk("rst_tok_words",  32'(word_cnt - w0), 32'd1);
    chk("rst_tok_word",   last_word,          32'h0000000C);
    chk("rst_tok_digits", 32'(last_digits),   32'd1);

    // ---------------- reset mid-EMIT ----------------
    out_ready = 1'b0;
    send_text("5\n");
    @(negedge clk);
    chk("emit_pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    w0 = word_cnt;
    @(negedge clk);
    chk("emit_rst_valid", 32'(out_valid), 32'd0);
    chk("emit_rst_ready", 32'(in_ready),  32'd1);
    chk("emit_rst_word",  out_word,       32'd0);
    idle(3);
    chk("emit_rst_nowords", 32'(word_cnt - w0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hex_word_parser
`default_nettype wire
